bcd_counter_multi: RTL and testbench

Parametrised multi-digit BCD up/down counter, the successor to the single-decade BCD counter. It counts across `DIGITS` cascaded decades with a ripple-free, same-cycle carry/borrow chain. It adds direction control, count enable, synchronous parallel load with digit validation, and terminal-count and wrap flags. It is intended for display, timer and event-tally datapaths that need decimal-native values without a binary-to-BCD converter.

---
 rtl/bcd_counter_multi_if.sv | 24 ++
 rtl/bcd_counter_multi.sv | 116 +++++++++++
 tb/tb_bcd_counter_multi.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bcd_counter_multi_if.sv
// Bus bundle for bcd_counter_multi: count controls, load port and status flags.
// The master drives the controls; the counter (slave) returns the count and flags.
interface bcd_counter_multi_if #(
   parameter int DIGITS = 4
);
   logic                  en;
   logic                  up;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   q;
   logic                  tc;
   logic                  wrap;
   logic                  load_err;

   modport master (
      output en, up, load, load_val,
      input  q, tc, wrap, load_err
   );

   modport slave (
      input  en, up, load, load_val,
      output q, tc, wrap, load_err
   );
endinterface

// File: rtl/bcd_counter_multi.sv
// bcd_counter_multi: DIGITS-decade BCD up/down counter with same-cycle
// carry/borrow, load priority with per-digit validation, terminal count,
// wrap and load-error pulses.
// Build option: define BCD_CNT_SAT_EN to saturate at all-9s / all-0s
// instead of wrapping modulo 10^DIGITS.

// Per-decade next-value logic. Purely combinational; the top owns the state.
module bcd_counter_multi_digit (
   input  logic       up_i,      // direction: 1 = increment
   input  logic       step_i,    // all lower decades are at their terminal value
   input  logic [3:0] d_i,       // current decade value (always 0-9)
   input  logic [3:0] ld_val_i,  // raw load nibble
   output logic       term_o,    // decade sits at 9 (up) or 0 (down)
   output logic [3:0] cnt_o,     // value after one count step
   output logic [3:0] ld_o,      // validated load nibble
   output logic       bad_o      // load nibble was 10-15
);
   // Terminal detect and one-step count for this decade
   always_comb begin
      term_o = up_i ? (d_i == 4'd9) : (d_i == 4'd0);
      cnt_o  = d_i;
      if (step_i) begin
         if (up_i) cnt_o = term_o ? 4'd0 : d_i + 4'd1;
         else      cnt_o = term_o ? 4'd9 : d_i - 4'd1;
      end
   end

   // Non-decimal load nibbles are forced to 0 so q never holds an illegal digit
   always_comb begin
      bad_o = (ld_val_i > 4'd9);
      ld_o  = bad_o ? 4'd0 : ld_val_i;
   end
endmodule

module bcd_counter_multi #(
   parameter int DIGITS = 4   // 1..8 decades
) (
   input  logic                  clk,
   input  logic                  rst,
   bcd_counter_multi_if.slave    bus
);
   logic [DIGITS-1:0][3:0] q_q, q_d;
   logic [DIGITS-1:0][3:0] cnt_vec;
   logic [DIGITS-1:0][3:0] ld_vec;
   logic [DIGITS-1:0]      term;
   logic [DIGITS-1:0]      bad;
   logic [DIGITS:0]        chain;
   logic                   all_term;
   logic                   tc;
   logic                   wrap_q, wrap_d;
   logic                   load_err_q, load_err_d;

   // Carry/borrow enable chain: decade i steps only when every lower decade is terminal
   always_comb begin
      chain[0] = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         chain[i+1] = chain[i] & term[i];
   end

   assign all_term = chain[DIGITS];

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_dig
         bcd_counter_multi_digit u_dig (
            .up_i     (bus.up),
            .step_i   (chain[g]),
            .d_i      (q_q[g]),
            .ld_val_i (bus.load_val[4*g +: 4]),
            .term_o   (term[g]),
            .cnt_o    (cnt_vec[g]),
            .ld_o     (ld_vec[g]),
            .bad_o    (bad[g])
         );
      end
   endgenerate

   // Terminal count: combinational so it can enable a further cascaded counter
   assign tc = bus.en & ~bus.load & all_term;

   // Next state: load beats count beats hold; a terminal step flags wrap
   always_comb begin
      q_d        = q_q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      if (bus.load) begin
         q_d        = ld_vec;
         load_err_d = |bad;
      end else if (bus.en) begin
         q_d    = cnt_vec;
         wrap_d = all_term;
`ifdef BCD_CNT_SAT_EN
         // Saturate: the overflowing step is blocked but still reported via wrap
         if (all_term) q_d = q_q;
`endif
      end
   end

   // State registers, cleared asynchronously so a pending operation is discarded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q        <= '0;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         q_q        <= q_d;
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.q        = q_q;
   assign bus.tc       = tc;
   assign bus.wrap     = wrap_q;
   assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_counter_multi.sv
// Scoreboard bench for bcd_counter_multi (DIGITS=2). The stimulus process
// pushes the expected post-edge state; the monitor pops and compares after
// every rising edge. tc is checked combinationally as inputs are applied.
module tb_bcd_counter_multi;
   typedef struct packed {
      logic [7:0] q;
      logic       w;
      logic       e;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic [7:0] cur = 8'h00;

   bcd_counter_multi_if #(.DIGITS(2)) bus ();

   bcd_counter_multi #(.DIGITS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Apply one cycle of inputs, check tc now, queue the state expected after the edge
   task automatic cyc(input logic e, input logic u, input logic l, input logic [7:0] lv,
                      input logic [7:0] eq, input logic ew, input logic ee);
      logic etc;
      @(negedge clk);
      bus.en = e; bus.up = u; bus.load = l; bus.load_val = lv;
      #1;
      etc = e & ~l & (u ? (cur == 8'h99) : (cur == 8'h00));
      chk("tc", {7'd0, bus.tc}, {7'd0, etc});
      sb.push_back('{q: eq, w: ew, e: ee});
      cur = eq;
   endtask

   // Monitor: every edge that has an expectation queued is compared
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("q", bus.q, x.q);
            chk("wrap", {7'd0, bus.wrap}, {7'd0, x.w});
            chk("load_err", {7'd0, bus.load_err}, {7'd0, x.e});
         end
      end
   end

   initial begin
      bus.en = 1'b0; bus.up = 1'b0; bus.load = 1'b0; bus.load_val = 8'h00;
      #3;
      chk("rst_q", bus.q, 8'h00);
      chk("rst_wrap", {7'd0, bus.wrap}, 8'h00);
      chk("rst_err", {7'd0, bus.load_err}, 8'h00);
      chk("rst_tc", {7'd0, bus.tc}, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Full up count 00 -> 99 -> 00, wrap with the returning 00
      for (int k = 0; k < 100; k++)
         cyc(1, 1, 0, 8'h00, bcd((k + 1) % 100), k == 99, 0);

      // Down count from 10 through 00 to 99
      cyc(0, 0, 1, 8'h10, 8'h10, 0, 0);
      for (int k = 9; k >= 0; k--)
         cyc(1, 0, 0, 8'h00, bcd(k), 0, 0);
      cyc(1, 0, 0, 8'h00, 8'h99, 1, 0);
      cyc(1, 1, 0, 8'h00, 8'h00, 1, 0);

      // Load validation, including back-to-back errors
      cyc(0, 0, 1, 8'hA7, 8'h07, 0, 1);
      cyc(0, 0, 1, 8'h59, 8'h59, 0, 0);
      cyc(0, 0, 1, 8'hFF, 8'h00, 0, 1);
      cyc(0, 0, 1, 8'h3B, 8'h30, 0, 1);
      cyc(0, 0, 0, 8'h00, 8'h30, 0, 0);

      // Load beats count; direction follows up on the same edge
      cyc(1, 1, 1, 8'h42, 8'h42, 0, 0);
      cyc(1, 1, 0, 8'h00, 8'h43, 0, 0);
      cyc(1, 0, 0, 8'h00, 8'h42, 0, 0);
      cyc(1, 1, 0, 8'h00, 8'h43, 0, 0);
      cyc(0, 1, 0, 8'h00, 8'h43, 0, 0);
      cyc(0, 0, 1, 8'h99, 8'h99, 0, 0);
      cyc(1, 1, 1, 8'h99, 8'h99, 0, 0);
      cyc(0, 1, 0, 8'h00, 8'h99, 0, 0);
      cyc(1, 0, 0, 8'h00, 8'h98, 0, 0);

      // Overflow behaviour at both ends
      cyc(0, 0, 1, 8'h98, 8'h98, 0, 0);
`ifdef BCD_CNT_SAT_EN
      cyc(1, 1, 0, 8'h00, 8'h99, 0, 0);
      cyc(1, 1, 0, 8'h00, 8'h99, 1, 0);
      cyc(1, 1, 0, 8'h00, 8'h99, 1, 0);
      cyc(0, 0, 1, 8'h01, 8'h01, 0, 0);
      cyc(1, 0, 0, 8'h00, 8'h00, 0, 0);
      cyc(1, 0, 0, 8'h00, 8'h00, 1, 0);
      cyc(1, 0, 0, 8'h00, 8'h00, 1, 0);
`else
      cyc(1, 1, 0, 8'h00, 8'h99, 0, 0);
      cyc(1, 1, 0, 8'h00, 8'h00, 1, 0);
      cyc(1, 1, 0, 8'h00, 8'h01, 0, 0);
      cyc(1, 0, 0, 8'h00, 8'h00, 0, 0);
      cyc(1, 0, 0, 8'h00, 8'h99, 1, 0);
      cyc(1, 0, 0, 8'h00, 8'h98, 0, 0);
`endif

      // Asynchronous reset between edges while counting
      cyc(0, 0, 1, 8'h56, 8'h56, 0, 0);
      cyc(1, 1, 0, 8'h00, 8'h57, 0, 0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_q", bus.q, 8'h00);
      chk("async_wrap", {7'd0, bus.wrap}, 8'h00);
      chk("async_err", {7'd0, bus.load_err}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      sb.push_back('{q: 8'h01, w: 1'b0, e: 1'b0});
      cur = 8'h01;
      cyc(0, 1, 0, 8'h00, 8'h01, 0, 0);

      // Drain the scoreboard with a bounded wait
      for (int n = 0; n < 10 && sb.size() > 0; n++)
         @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
